tc_sram_arb: RTL and testbench



---
 rtl/tc_sram_pkg.sv | 25 ++
 rtl/tc_sram_rsp_slot.sv | 73 +++++++
 rtl/tc_sram_arb.sv | 113 +++++++++++
 tb/tb_tc_sram_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_sram_pkg.sv
`default_nettype none
// tc_sram_pkg: shared constants, response-slot state encoding and the request record.
// Revision 1.0

package tc_sram_pkg;

  localparam int TC_SRAM_AW = 10;
  localparam int TC_SRAM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUED = 2'd1,
    ST_HOLD   = 2'd2
  } port_state_e;

  typedef struct packed {
    logic [TC_SRAM_AW-1:0]   addr;
    logic                    wren;
    logic [TC_SRAM_DW-1:0]   wdata;
    logic [TC_SRAM_DW/8-1:0] mask;
  } sram_req_t;

endpackage

`default_nettype wire

// File: rtl/tc_sram_rsp_slot.sv
`default_nettype none
// tc_sram_rsp_slot: per-port response tracker; passes SRAM data through, or holds it under back-pressure.
// Revision 1.0

module tc_sram_rsp_slot
  import tc_sram_pkg::*;
#(
  parameter int DW = TC_SRAM_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          accept_i,
  input  logic          rsp_ready_i,
  input  logic [DW-1:0] sram_data_i,
  output logic          eligible_o,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rdata_o
);

  port_state_e   state_q, state_d;
  logic [DW-1:0] hold_q, hold_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_i) state_d = ST_ISSUED;
      end
      ST_ISSUED: begin
        if (rsp_ready_i) begin
          state_d = accept_i ? ST_ISSUED : ST_IDLE;
        end else begin
          // Macro output is only valid this one cycle, so capture it now.
          state_d = ST_HOLD;
          hold_d  = sram_data_i;
        end
      end
      ST_HOLD: begin
        if (rsp_ready_i) state_d = accept_i ? ST_ISSUED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A busy slot frees up in the same cycle its response is consumed.
  assign eligible_o  = (state_q == ST_IDLE) || rsp_ready_i;
  assign rsp_valid_o = !rst_i && (state_q != ST_IDLE);

  always_comb begin
    rdata_o = '0;
    if (!rst_i) begin
      case (state_q)
        ST_ISSUED: rdata_o = sram_data_i;
        ST_HOLD:   rdata_o = hold_q;
        default:   rdata_o = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/tc_sram_arb.sv
`default_nettype none
// tc_sram_arb: two-port round-robin / fixed-priority arbiter and sequencer for a 1024x32 byte-masked SRAM.
// Revision 1.0

module tc_sram_arb
  import tc_sram_pkg::*;
#(
  parameter int AW         = TC_SRAM_AW,
  parameter int DW         = TC_SRAM_DW,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            p0_req_valid_i,
  output logic            p0_req_ready_o,
  input  logic [AW-1:0]   p0_addr_i,
  input  logic            p0_wren_i,
  input  logic [DW-1:0]   p0_wdata_i,
  input  logic [DW/8-1:0] p0_mask_i,
  output logic            p0_rsp_valid_o,
  input  logic            p0_rsp_ready_i,
  output logic [DW-1:0]   p0_rdata_o,
  input  logic            p1_req_valid_i,
  output logic            p1_req_ready_o,
  input  logic [AW-1:0]   p1_addr_i,
  input  logic            p1_wren_i,
  input  logic [DW-1:0]   p1_wdata_i,
  input  logic [DW/8-1:0] p1_mask_i,
  output logic            p1_rsp_valid_o,
  input  logic            p1_rsp_ready_i,
  output logic [DW-1:0]   p1_rdata_o,
  output logic            sram_cs_o,
  output logic            sram_wren_o,
  output logic [AW-1:0]   sram_addr_o,
  output logic [DW-1:0]   sram_data_o,
  output logic [DW/8-1:0] sram_mask_o,
  input  logic [DW-1:0]   sram_data_i
);

  logic      elig0, elig1, want0, want1, gnt0, gnt1;
  logic      last_q, last_d;
  sram_req_t req0, req1, sel;

  assign want0 = p0_req_valid_i && elig0 && !rst_i;
  assign want1 = p1_req_valid_i && elig1 && !rst_i;

  // last_q == 1 means port 1 was granted most recently, so port 0 wins a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (want0 && want1) begin
      if ((FIXED_PRIO != 0) || last_q) gnt0 = 1'b1;
      else                             gnt1 = 1'b1;
    end else begin
      gnt0 = want0;
      gnt1 = want1;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt0)      last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  assign p0_req_ready_o = gnt0;
  assign p1_req_ready_o = gnt1;

  assign req0 = '{addr: p0_addr_i, wren: p0_wren_i, wdata: p0_wdata_i, mask: p0_mask_i};
  assign req1 = '{addr: p1_addr_i, wren: p1_wren_i, wdata: p1_wdata_i, mask: p1_mask_i};

  always_comb begin
    sel = '0;
    if (gnt0)      sel = req0;
    else if (gnt1) sel = req1;
  end

  assign sram_cs_o   = gnt0 || gnt1;
  assign sram_wren_o = sel.wren;
  assign sram_addr_o = sel.addr;
  assign sram_data_o = sel.wdata;
  assign sram_mask_o = sel.wren ? sel.mask : '0;

  tc_sram_rsp_slot #(.DW(DW)) u_slot0 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .accept_i    (gnt0),
    .rsp_ready_i (p0_rsp_ready_i),
    .sram_data_i (sram_data_i),
    .eligible_o  (elig0),
    .rsp_valid_o (p0_rsp_valid_o),
    .rdata_o     (p0_rdata_o)
  );

  tc_sram_rsp_slot #(.DW(DW)) u_slot1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .accept_i    (gnt1),
    .rsp_ready_i (p1_rsp_ready_i),
    .sram_data_i (sram_data_i),
    .eligible_o  (elig1),
    .rsp_valid_o (p1_rsp_valid_o),
    .rdata_o     (p1_rdata_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_tc_sram_arb.sv
`default_nettype none
// tb_tc_sram_arb: vector table, scoreboard and corner-case sequences for tc_sram_arb.
// Revision 1.0

module tb_tc_sram_arb;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Round-robin DUT, port-indexed stimulus
  logic        req_valid [2];
  logic        req_ready [2];
  logic [9:0]  addr      [2];
  logic        wren      [2];
  logic [31:0] wdata     [2];
  logic [3:0]  mask      [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rdata     [2];
  logic        sram_cs, sram_wren;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [3:0]  sram_mask;

  // Fixed-priority DUT (arbitration only)
  logic        f_valid [2];
  logic        f_ready [2];
  logic        f_rsp_valid [2];
  logic [31:0] f_rdata [2];
  logic        f_cs, f_wren;
  logic [9:0]  f_addr;
  logic [31:0] f_wdata;
  logic [3:0]  f_mask;
  logic [31:0] f_sram_din;

  tc_sram_arb #(.AW(10), .DW(32), .FIXED_PRIO(0)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .p0_req_valid_i(req_valid[0]), .p0_req_ready_o(req_ready[0]), .p0_addr_i(addr[0]),
    .p0_wren_i(wren[0]), .p0_wdata_i(wdata[0]), .p0_mask_i(mask[0]),
    .p0_rsp_valid_o(rsp_valid[0]), .p0_rsp_ready_i(rsp_ready[0]), .p0_rdata_o(rdata[0]),
    .p1_req_valid_i(req_valid[1]), .p1_req_ready_o(req_ready[1]), .p1_addr_i(addr[1]),
    .p1_wren_i(wren[1]), .p1_wdata_i(wdata[1]), .p1_mask_i(mask[1]),
    .p1_rsp_valid_o(rsp_valid[1]), .p1_rsp_ready_i(rsp_ready[1]), .p1_rdata_o(rdata[1]),
    .sram_cs_o(sram_cs), .sram_wren_o(sram_wren), .sram_addr_o(sram_addr),
    .sram_data_o(sram_wdata), .sram_mask_o(sram_mask), .sram_data_i(sram_rdata)
  );

  tc_sram_arb #(.AW(10), .DW(32), .FIXED_PRIO(1)) u_dut_fp (
    .clk_i(clk), .rst_i(rst_i),
    .p0_req_valid_i(f_valid[0]), .p0_req_ready_o(f_ready[0]), .p0_addr_i(10'd1),
    .p0_wren_i(1'b0), .p0_wdata_i(32'd0), .p0_mask_i(4'd0),
    .p0_rsp_valid_o(f_rsp_valid[0]), .p0_rsp_ready_i(1'b1), .p0_rdata_o(f_rdata[0]),
    .p1_req_valid_i(f_valid[1]), .p1_req_ready_o(f_ready[1]), .p1_addr_i(10'd2),
    .p1_wren_i(1'b0), .p1_wdata_i(32'd0), .p1_mask_i(4'd0),
    .p1_rsp_valid_o(f_rsp_valid[1]), .p1_rsp_ready_i(1'b1), .p1_rdata_o(f_rdata[1]),
    .sram_cs_o(f_cs), .sram_wren_o(f_wren), .sram_addr_o(f_addr),
    .sram_data_o(f_wdata), .sram_mask_o(f_mask), .sram_data_i(f_sram_din)
  );

  // Behavioural macro: byte-masked write, registered read, one-cycle latency.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_wren) begin
        for (int b = 0; b < 4; b++)
          if (sram_mask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      sram_rdata <= mem[sram_addr];
    end
  end

  // Reference model of array contents plus per-port expected responses.
  typedef struct {
    logic        is_read;
    logic [31:0] data;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];
  logic [31:0] ref_mem [1024];
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_port(input int p);
    exp_t e;
    int   sz;
    sz = (p == 0) ? sb0.size() : sb1.size();
    chk($sformatf("p%0d_rsp_valid_vs_pending", p), {31'd0, rsp_valid[p]}, {31'd0, sz != 0});
    if (rsp_valid[p] && rsp_ready[p] && sz != 0) begin
      e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
      if (e.is_read) chk($sformatf("p%0d_sb_rdata", p), rdata[p], e.data);
    end
    if (req_valid[p] && req_ready[p]) begin
      chk($sformatf("p%0d_sram_addr", p), {22'd0, sram_addr}, {22'd0, addr[p]});
      chk($sformatf("p%0d_sram_wren", p), {31'd0, sram_wren}, {31'd0, wren[p]});
      if (wren[p]) begin
        chk($sformatf("p%0d_sram_wdata", p), sram_wdata, wdata[p]);
        chk($sformatf("p%0d_sram_mask", p), {28'd0, sram_mask}, {28'd0, mask[p]});
        for (int b = 0; b < 4; b++)
          if (mask[p][b]) ref_mem[addr[p]][8*b +: 8] = wdata[p][8*b +: 8];
      end
      e.is_read = !wren[p];
      e.data    = ref_mem[addr[p]];
      if (p == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst_i) begin
      mon_port(0);
      mon_port(1);
      chk("single_grant", {31'd0, req_ready[0] && req_ready[1]}, 32'd0);
      if (!sram_cs)
        chk("idle_sram_zero", {sram_wren, sram_addr, sram_mask} | sram_wdata, 32'd0);
      else if (!sram_wren)
        chk("read_mask_zero", {28'd0, sram_mask}, 32'd0);
    end
  end

  always @(posedge clk) begin
    if (rst_i) begin
      sb0.delete();
      sb1.delete();
    end
  end

  typedef struct {
    int          port;
    logic        wren;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;
  vec_t vec [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {26'd0, req_ready[0], req_ready[1], rsp_valid[0], rsp_valid[1], sram_cs, sram_wren}, 32'd0);
    chk({name, "_sram"}, {18'd0, sram_addr, sram_mask} | sram_wdata, 32'd0);
    chk({name, "_rdata"}, rdata[0] | rdata[1], 32'd0);
  endtask

  task automatic drive(input int p, input logic v, input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    req_valid[p] = v; wren[p] = w; addr[p] = a; wdata[p] = d; mask[p] = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
    f_sram_din = 32'd0;
    vec[0]  = '{0, 1'b1, 10'd5,   32'hDEADBEEF, 4'hF, 32'h0};
    vec[1]  = '{0, 1'b0, 10'd5,   32'h0,        4'h0, 32'hDEADBEEF};
    vec[2]  = '{1, 1'b1, 10'd5,   32'h000000AA, 4'h1, 32'h0};
    vec[3]  = '{0, 1'b0, 10'd5,   32'h0,        4'h0, 32'hDEADBEAA};
    vec[4]  = '{1, 1'b1, 10'd5,   32'h0,        4'h0, 32'h0};
    vec[5]  = '{0, 1'b0, 10'd5,   32'h0,        4'h0, 32'hDEADBEAA};
    vec[6]  = '{1, 1'b1, 10'd7,   32'h12345678, 4'hF, 32'h0};
    vec[7]  = '{1, 1'b0, 10'd7,   32'h0,        4'h0, 32'h12345678};
    vec[8]  = '{0, 1'b1, 10'h3FF, 32'hA5A5A5A5, 4'hC, 32'h0};
    vec[9]  = '{1, 1'b0, 10'h3FF, 32'h0,        4'h0, 32'hA5A50000};
    vec[10] = '{0, 1'b1, 10'd0,   32'h11223344, 4'hF, 32'h0};
    vec[11] = '{1, 1'b0, 10'd0,   32'h0,        4'h0, 32'h11223344};

    rst_i = 1'b1;
    for (int p = 0; p < 2; p++) begin
      drive(p, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
      rsp_ready[p] = 1'b1;
      f_valid[p]   = 1'b0;
    end
    repeat (3) step();
    @(negedge clk);
    chk_all_zero("in_reset");
    step();
    rst_i  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk_all_zero("after_reset");
    step();

    // Single transactions from the table
    for (int i = 0; i < 12; i++) begin
      drive(vec[i].port, 1'b1, vec[i].wren, vec[i].addr, vec[i].wdata, vec[i].mask);
      n = 0;
      @(negedge clk);
      while (!req_ready[vec[i].port] && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("vec%0d_accept", i), {31'd0, req_ready[vec[i].port]}, 32'd1);
      step();
      req_valid[vec[i].port] = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_rsp_valid", i), {31'd0, rsp_valid[vec[i].port]}, 32'd1);
      if (!vec[i].wren) chk($sformatf("vec%0d_rdata", i), rdata[vec[i].port], vec[i].exp);
      step();
    end

    // Both ports streaming: strict alternation, starting with port 0
    drive(0, 1'b1, 1'b0, 10'd5, 32'd0, 4'd0);
    drive(1, 1'b1, 1'b0, 10'd7, 32'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_p0", i), {31'd0, req_ready[0]}, {31'd0, (i % 2) == 0});
      chk($sformatf("rr%0d_p1", i), {31'd0, req_ready[1]}, {31'd0, (i % 2) == 1});
      chk($sformatf("rr%0d_cs", i), {31'd0, sram_cs}, 32'd1);
      step();
    end
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    repeat (3) step();

    // Port 0 back-pressured while port 1 keeps the macro busy
    rsp_ready[0] = 1'b0;
    drive(0, 1'b1, 1'b0, 10'd7, 32'd0, 4'd0);
    @(negedge clk);
    chk("hold_accept", {31'd0, req_ready[0]}, 32'd1);
    step();
    drive(1, 1'b1, 1'b0, 10'd5, 32'd0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), {31'd0, rsp_valid[0]}, 32'd1);
      chk($sformatf("hold%0d_rdata", k), rdata[0], 32'h12345678);
      chk($sformatf("hold%0d_p0_ready", k), {31'd0, req_ready[0]}, 32'd0);
      chk($sformatf("hold%0d_p1_ready", k), {31'd0, req_ready[1]}, 32'd1);
      step();
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("hold_release_b2b", {31'd0, req_ready[0]}, 32'd1);
    step();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    repeat (3) step();
    chk("drain_p0", sb0.size(), 32'd0);
    chk("drain_p1", sb1.size(), 32'd0);

    // Fixed priority: port 1 starves until port 0 backs off
    f_valid[0] = 1'b1;
    f_valid[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("fp%0d", i), {30'd0, f_ready[0], f_ready[1]}, 32'd2);
      step();
    end
    f_valid[0] = 1'b0;
    @(negedge clk);
    chk("fp_gap_p1", {30'd0, f_ready[0], f_ready[1]}, 32'd1);
    step();
    f_valid[0] = 1'b1;
    @(negedge clk);
    chk("fp_resume_p0", {30'd0, f_ready[0], f_ready[1]}, 32'd2);
    step();
    f_valid[0] = 1'b0;
    f_valid[1] = 1'b0;
    step();

    // Reset right after a read is accepted
    drive(0, 1'b1, 1'b0, 10'd7, 32'd0, 4'd0);
    @(negedge clk);
    chk("rst_accept", {31'd0, req_ready[0]}, 32'd1);
    step();
    rst_i = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst_no_rsp", {31'd0, rsp_valid[0]}, 32'd0);
    step();
    rst_i = 1'b0;
    @(negedge clk);
    chk_all_zero("post_rst");
    step();
    drive(0, 1'b1, 1'b0, 10'd5, 32'd0, 4'd0);
    drive(1, 1'b1, 1'b0, 10'd7, 32'd0, 4'd0);
    @(negedge clk);
    chk("post_rst_tie", {30'd0, req_ready[0], req_ready[1]}, 32'd2);
    step();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    repeat (4) step();
    chk("final_drain", sb0.size() + sb1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
